// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive word packer.
//   WORD_W / BYTE_W / BYTES_PER_WORD : word geometry (4 little-endian bytes per word)
//   byte_idx_t                       : lane index of the next byte within a word
//   word_t                           : packed 32-bit word
//   LAST_IDX                         : lane index whose byte completes a word
package uart_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [1:0]        byte_idx_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through FIFO of 32-bit words.
//   clk, rstn  : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request; accepted when not full, or when a pop happens in the same cycle
//   pop        : read request; ignored when empty
//   dout       : head word, forced to 0 while empty
//   full/empty : occupancy flags
//   count      : words held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module word_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  word_t                  din,
  output word_t                  dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign rd_en = pop && !empty;
  // When full, a same-cycle pop frees the slot the write lands in (wr_ptr == rd_ptr).
  assign wr_en = push && (!full || rd_en);

  // NOTE: storage is deliberately not reset; dout is gated by empty, so
  // stale contents are never visible and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs the UART receiver's byte stream into little-endian 32-bit words and
// buffers them in a FWFT FIFO with a valid/ready interface.
//   clk, rstn     : clock, asynchronous active-low reset
//   byte_in       : received byte, qualified by the one-cycle byte_valid pulse
//   ferr_in       : framing-error level; bytes are ignored while it is high
//   word_out      : head word {b3,b2,b1,b0}, b0 received first; 0 when empty
//   word_valid    : FIFO non-empty; word_ready accepts the head word
//   count         : words held
//   overflow      : sticky, a completed word was dropped because the FIFO was full
//   frame_err     : sticky, rising edge of ferr_in seen
//   clear_err     : clears both sticky flags (a same-cycle set event wins)
//   timeout_pulse : one-cycle pulse when an idle partial word is discarded
//                   (present only with UART_RX_WORD_TIMEOUT_EN defined)
// Optional feature macro: UART_RX_WORD_TIMEOUT_EN. Without it partial words
// wait indefinitely for their remaining bytes.
module uart_rx_word_packer
  import uart_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [BYTE_W-1:0]      byte_in,
  input  logic                   byte_valid,
  input  logic                   ferr_in,
  output word_t                  word_out,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   frame_err,
  input  logic                   clear_err
`ifdef UART_RX_WORD_TIMEOUT_EN
  ,
  output logic                   timeout_pulse
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CLKS < 2) begin : g_param_check
    $error("uart_rx_word_packer: DEPTH must be a power of two >= 2, TIMEOUT_CLKS >= 2");
  end

  byte_idx_t                idx;
  logic [WORD_W-BYTE_W-1:0] lanes;     // bytes 0..2 of the word being assembled
  logic                     ferr_q;
  logic                     ferr_rise;
  logic                     byte_acc;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic                     drop;
  logic                     timeout_fire;

  assign ferr_rise  = ferr_in && !ferr_q;
  assign byte_acc   = byte_valid && !ferr_in;
  // The 4th byte goes straight into the FIFO alongside the three stored lanes.
  assign push       = byte_acc && (idx == LAST_IDX);
  assign word_valid = !empty;
  assign pop        = word_valid && word_ready;
  assign drop       = push && full && !pop;

  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   ({byte_in, lanes}),
    .dout  (word_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx    <= '0;
      lanes  <= '0;
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= ferr_in;
      // A completed word wraps idx to 0 even when it is dropped.
      if (ferr_rise || timeout_fire) begin
        idx <= '0;
      end else if (byte_acc) begin
        idx <= idx + byte_idx_t'(1);
        case (idx)
          2'd0:    lanes[0*BYTE_W +: BYTE_W] <= byte_in;
          2'd1:    lanes[1*BYTE_W +: BYTE_W] <= byte_in;
          2'd2:    lanes[2*BYTE_W +: BYTE_W] <= byte_in;
          default: ;
        endcase
      end
    end
  end

  // Set events take priority over clear_err.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)           overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (ferr_rise)      frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
    end
  end

`ifdef UART_RX_WORD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS);

  logic [TO_W-1:0] to_cnt;

  // An accepted byte in the would-be timeout cycle wins.
  assign timeout_fire = (idx != '0) && !byte_acc && !ferr_rise &&
                        (to_cnt == TO_W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt        <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout_fire;
      if (idx == '0 || byte_acc || ferr_rise || timeout_fire) to_cnt <= '0;
      else                                                     to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Self-checking bench for uart_rx_word_packer. A queue-based reference model
// tracks pending bytes and stored words; every cycle the DUT outputs are
// compared against it, plus directed checks with hand-computed constants.
module tb_uart_rx_word_packer;

  localparam int DEPTH = 8;
  localparam int TO    = 16;

  logic        clk;
  logic        rstn;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        ferr_in;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [3:0]  count;
  logic        overflow;
  logic        frame_err;
  logic        clear_err;
`ifdef UART_RX_WORD_TIMEOUT_EN
  logic        timeout_pulse;
`endif

  uart_rx_word_packer #(.DEPTH(DEPTH), .TIMEOUT_CLKS(TO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .ferr_in    (ferr_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .count      (count),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .clear_err  (clear_err)
`ifdef UART_RX_WORD_TIMEOUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0]  pend[$];
  logic [31:0] q[$];
  logic        m_ferr_prev = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_ferr = 1'b0;
  logic        m_pulse = 1'b0;
  int          m_idle = 0;

  task automatic model_reset();
    pend.delete();
    q.delete();
    m_ferr_prev = 1'b0;
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    m_pulse = 1'b0;
    m_idle = 0;
  endtask

  // Applies one clock edge's worth of the behavioural rules to the model.
  task automatic model_step();
    logic        pop_m, push_m, rise, acc, ovf_set;
    logic [31:0] w;
    pop_m   = (q.size() != 0) && word_ready;
    rise    = ferr_in && !m_ferr_prev;
    acc     = byte_valid && !ferr_in;
    push_m  = 1'b0;
    m_pulse = 1'b0;
    w       = '0;
    if (rise) begin
      pend.delete();
    end else if (acc) begin
      pend.push_back(byte_in);
      if (pend.size() == 4) begin
        w = {pend[3], pend[2], pend[1], pend[0]};
        pend.delete();
        push_m = 1'b1;
      end
    end
`ifdef UART_RX_WORD_TIMEOUT_EN
    if (rise || acc || pend.size() == 0) begin
      m_idle = 0;
    end else if (m_idle == TO - 1) begin
      pend.delete();
      m_pulse = 1'b1;
      m_idle = 0;
    end else begin
      m_idle++;
    end
`endif
    ovf_set = push_m && (q.size() == DEPTH) && !pop_m;
    if (pop_m) void'(q.pop_front());
    if (push_m && !ovf_set) q.push_back(w);
    if (ovf_set)        m_ovf = 1'b1;
    else if (clear_err) m_ovf = 1'b0;
    if (rise)           m_ferr = 1'b1;
    else if (clear_err) m_ferr = 1'b0;
    m_ferr_prev = ferr_in;
  endtask

  task automatic compare_all();
    check("m_valid", 32'(word_valid), 32'(q.size() != 0));
    check("m_count", 32'(count), 32'(q.size()));
    if (q.size() != 0) check("m_word", word_out, q[0]);
    check("m_overflow", 32'(overflow), 32'(m_ovf));
    check("m_frame_err", 32'(frame_err), 32'(m_ferr));
`ifdef UART_RX_WORD_TIMEOUT_EN
    check("m_timeout", 32'(timeout_pulse), 32'(m_pulse));
`endif
  endtask

  // Inputs change on the falling edge; outputs are compared on the next falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    cycle();
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain_and_clear();
    word_ready = 1'b1;
    idle(DEPTH + 1);
    word_ready = 1'b0;
    clear_err  = 1'b1;
    cycle();
    clear_err  = 1'b0;
  endtask

  function automatic logic [31:0] pat_word(input int k);
    logic [3:0] kk;
    kk = 4'(k);
    return {kk, 4'd3, kk, 4'd2, kk, 4'd1, kk, 4'd0};
  endfunction

  initial begin
    rstn       = 1'b0;
    byte_in    = '0;
    byte_valid = 1'b0;
    ferr_in    = 1'b0;
    word_ready = 1'b0;
    clear_err  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_word", word_out, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rstn = 1'b1;
    cycle();

    // Basic packing with a ready consumer
    word_ready = 1'b1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("t1_valid", 32'(word_valid), 32'd1);
    check("t1_word", word_out, 32'h44332211);
    cycle();
    check("t1_count0", 32'(count), 32'd0);

    // Fill past full: 9th word lost, overflow set
    word_ready = 1'b0;
    for (int k = 0; k < 9; k++)
      for (int j = 0; j < 4; j++) send_byte({4'(k), 4'(j)});
    check("t2_count8", 32'(count), 32'd8);
    check("t2_overflow", 32'(overflow), 32'd1);
    word_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("t2_drain", word_out, pat_word(k));
      cycle();
    end
    check("t2_empty", 32'(count), 32'd0);
    word_ready = 1'b0;

    // clear_err with no new event
    clear_err = 1'b1;
    cycle();
    clear_err = 1'b0;
    check("t5_clear", 32'(overflow), 32'd0);

    // Framing error discards the partial word
    send_byte(8'hAA); send_byte(8'hBB);
    ferr_in = 1'b1; byte_in = 8'hCC; byte_valid = 1'b1; cycle(); byte_valid = 1'b0;
    ferr_in = 1'b0; cycle();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("t3_frame_err", 32'(frame_err), 32'd1);
    check("t3_count", 32'(count), 32'd1);
    check("t3_word", word_out, 32'h04030201);
    drain_and_clear();
    check("t3_cleared", 32'(frame_err), 32'd0);

    // Push into a full FIFO with a same-cycle pop is accepted
    for (int i = 0; i < 4 * DEPTH + 3; i++) send_byte(8'($urandom));
    word_ready = 1'b1;
    send_byte(8'h5A);
    word_ready = 1'b0;
    check("t4_count8", 32'(count), 32'd8);
    check("t4_no_overflow", 32'(overflow), 32'd0);
    // clear_err coincident with a drop: the drop wins
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    clear_err = 1'b1;
    send_byte(8'hA5);
    clear_err = 1'b0;
    check("t5_drop_wins", 32'(overflow), 32'd1);
    drain_and_clear();

`ifdef UART_RX_WORD_TIMEOUT_EN
    begin
      int pulses = 0;
      send_byte(8'h55);
      for (int i = 0; i < TO; i++) begin
        cycle();
        if (timeout_pulse) pulses++;
      end
      check("t6_pulses", 32'(pulses), 32'd1);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      check("t6_word", word_out, 32'hEFBEADDE);
      drain_and_clear();
    end
`endif

    // Randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++) begin
        byte_in    = 8'($urandom);
        byte_valid = ($urandom_range(0, 1) == 1);
        ferr_in    = ($urandom_range(0, 29) == 0);
        word_ready = ($urandom_range(0, 99) < rdy_pct);
        clear_err  = ($urandom_range(0, 49) == 0);
        cycle();
      end
    end
    byte_valid = 1'b0; ferr_in = 1'b0; clear_err = 1'b0; word_ready = 1'b0;
    cycle();

    // Asynchronous reset mid-word with stored words
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    #3 rstn = 1'b0;
    #1;
    check("ar_valid", 32'(word_valid), 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_word", word_out, 32'd0);
    check("ar_overflow", 32'(overflow), 32'd0);
    check("ar_frame_err", 32'(frame_err), 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    check("ar_word_after", word_out, 32'hC4C3C2C1);
    check("ar_count_after", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
